// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: ALU writes win, multi-cycle results queue.
// Optional read-hazard compare enabled by defining WB_HAZARD_CHECK_EN.
module wb_write_arbiter #(
  parameter int W     = 5,
  parameter int B     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_wr_en,
  input  logic [W-1:0]               alu_w_addr,
  input  logic [B-1:0]               alu_w_data,
  input  logic                       mc_valid,
  output logic                       mc_ready,
  input  logic [W-1:0]               mc_w_addr,
  input  logic [B-1:0]               mc_w_data,
`ifdef WB_HAZARD_CHECK_EN
  input  logic [W-1:0]               r_addr_A,
  input  logic [W-1:0]               r_addr_B,
  output logic                       pend_hit,
`endif
  output logic                       wr_en,
  output logic [W-1:0]               w_addr,
  output logic [B-1:0]               w_data,
  output logic [$clog2(DEPTH+1)-1:0] pend_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]     fa_q [DEPTH];
  logic [W-1:0]     fa_d [DEPTH];
  logic [B-1:0]     fd_q [DEPTH];
  logic [B-1:0]     fd_d [DEPTH];
  logic [DEPTH-1:0] fl_q, fl_d;
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic [W-1:0]     w_addr_q, w_addr_d;
  logic [B-1:0]     w_data_q, w_data_d;

  logic alu_hit, push, store, pop;

  assign mc_ready   = cnt_q < FULL;
  assign wr_en      = wr_en_q;
  assign w_addr     = w_addr_q;
  assign w_data     = w_data_q;
  assign pend_count = cnt_q;

  // Arbitration, kill of stale queued writes, FIFO push/pop bookkeeping
  always_comb begin
    alu_hit  = alu_wr_en && (alu_w_addr != '0);
    push     = mc_valid && mc_ready;
    store    = push && (mc_w_addr != '0);
    pop      = !alu_hit && (cnt_q != '0);
    fa_d     = fa_q;
    fd_d     = fd_q;
    fl_d     = fl_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    if (alu_hit) begin
      wr_en_d  = 1'b1;
      w_addr_d = alu_w_addr;
      w_data_d = alu_w_data;
      for (int i = 0; i < DEPTH; i++)
        if (fa_q[i] == alu_w_addr) fl_d[i] = 1'b0;
    end else if (pop) begin
      wr_en_d    = fl_q[rp_q];
      w_addr_d   = fa_q[rp_q];
      w_data_d   = fd_q[rp_q];
      fl_d[rp_q] = 1'b0;
      rp_d       = rp_q + PW'(1);
    end
    // The incoming entry is younger than a same-cycle ALU write: not killed
    if (store) begin
      fa_d[wp_q] = mc_w_addr;
      fd_d[wp_q] = mc_w_data;
      fl_d[wp_q] = 1'b1;
      wp_d       = wp_q + PW'(1);
    end
    unique case ({store, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef WB_HAZARD_CHECK_EN
  logic a_nz, b_nz;
  // Read-after-write hazard against queued live entries and the port
  always_comb begin
    a_nz     = r_addr_A != '0;
    b_nz     = r_addr_B != '0;
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (fl_q[i] && ((a_nz && fa_q[i] == r_addr_A) ||
                      (b_nz && fa_q[i] == r_addr_B)))
        pend_hit = 1'b1;
    if (wr_en_q && ((a_nz && w_addr_q == r_addr_A) ||
                    (b_nz && w_addr_q == r_addr_B)))
      pend_hit = 1'b1;
  end
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      fa_q     <= '{default: '0};
      fd_q     <= '{default: '0};
      fl_q     <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      wr_en_q  <= 1'b0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      fa_q     <= fa_d;
      fd_q     <= fd_d;
      fl_q     <= fl_d;
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      wr_en_q  <= wr_en_d;
      w_addr_q <= w_addr_d;
      w_data_q <= w_data_d;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: queue-based reference model,
// per-cycle expected port values checked by an independent monitor.
module tb_wb_write_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr_en;
  logic [4:0]  alu_w_addr;
  logic [31:0] alu_w_data;
  logic        mc_valid;
  logic        mc_ready;
  logic [4:0]  mc_w_addr;
  logic [31:0] mc_w_data;
  logic        wr_en;
  logic [4:0]  w_addr;
  logic [31:0] w_data;
  logic [2:0]  pend_count;
`ifdef WB_HAZARD_CHECK_EN
  logic [4:0]  r_addr_A, r_addr_B;
  logic        pend_hit;
`endif

  always #5 clk = ~clk;

  wb_write_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_wr_en(alu_wr_en), .alu_w_addr(alu_w_addr),
    .alu_w_data(alu_w_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready),
    .mc_w_addr(mc_w_addr), .mc_w_data(mc_w_data),
`ifdef WB_HAZARD_CHECK_EN
    .r_addr_A(r_addr_A), .r_addr_B(r_addr_B),
    .pend_hit(pend_hit),
`endif
    .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .pend_count(pend_count)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  typedef struct {
    int          cyc;
    bit          en;
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;

  ent_t q[$];
  exp_t expq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit          cur_en = 1'b0;
  logic [4:0]  cur_a = '0;
  logic [31:0] cur_d = '0;
  int   max_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] ex);
    n_checks++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, ex);
    end
  endtask

  // Monitor: compares the port against the expectation for this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        chk("wr_en", 64'(wr_en), 64'(e.en));
        chk("w_addr", 64'(w_addr), 64'(e.a));
        chk("w_data", 64'(w_data), 64'(e.d));
      end
    end
  end

  // One clock of stimulus; the model decides the port value after the edge
  task automatic step(input bit rst, input bit ae, input logic [4:0] aa,
                      input logic [31:0] ad, input bit mv,
                      input logic [4:0] ma, input logic [31:0] md);
    bit   rdy;
    ent_t h;
    exp_t e;
    @(negedge clk);
    rdy = q.size() < 4;
    chk("pend_count", 64'(pend_count), 64'(q.size()));
    chk("mc_ready", 64'(mc_ready), 64'(rdy));
    if (q.size() > max_cnt) max_cnt = q.size();
    reset = rst; alu_wr_en = ae; alu_w_addr = aa; alu_w_data = ad;
    mc_valid = mv; mc_w_addr = ma; mc_w_data = md;
`ifdef WB_HAZARD_CHECK_EN
    begin
      bit hit = 0;
      r_addr_A = 5'($urandom_range(0, 9));
      r_addr_B = 5'($urandom_range(0, 9));
      foreach (q[i])
        if (q[i].live && ((r_addr_A != 0 && q[i].a == r_addr_A) ||
                          (r_addr_B != 0 && q[i].a == r_addr_B)))
          hit = 1;
      if (cur_en && ((r_addr_A != 0 && cur_a == r_addr_A) ||
                     (r_addr_B != 0 && cur_a == r_addr_B)))
        hit = 1;
      #1 chk("pend_hit", 64'(pend_hit), 64'(hit));
    end
`endif
    if (rst) begin
      q.delete();
      cur_en = 0; cur_a = '0; cur_d = '0;
    end else begin
      if (ae && aa != 0) begin
        foreach (q[i]) if (q[i].a == aa) q[i].live = 0;
        cur_en = 1; cur_a = aa; cur_d = ad;
      end else if (q.size() > 0) begin
        h = q.pop_front();
        cur_en = h.live; cur_a = h.a; cur_d = h.d;
      end else begin
        cur_en = 0;
      end
      if (mv && rdy && ma != 0) q.push_back('{a: ma, d: md, live: 1'b1});
    end
    e.cyc = cyc + 1; e.en = cur_en; e.a = cur_a; e.d = cur_d;
    expq.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    reset = 1; alu_wr_en = 0; alu_w_addr = '0; alu_w_data = '0;
    mc_valid = 0; mc_w_addr = '0; mc_w_data = '0;
`ifdef WB_HAZARD_CHECK_EN
    r_addr_A = '0; r_addr_B = '0;
`endif
    repeat (2) @(posedge clk);
    step(1, 0, '0, '0, 0, '0, '0);
    step(1, 0, '0, '0, 0, '0, '0);
    idle(2);

    // ALU only, then ALU to x0
    step(0, 1, 5'd3, 32'hA5A5_0001, 0, '0, '0);
    step(0, 1, 5'd0, 32'hDEAD_BEEF, 0, '0, '0);
    idle(1);

    // Fill while ALU busy, 5th offer refused, then drain in order
    for (int i = 1; i <= 4; i++)
      step(0, 1, 5'd20, 32'(100 + i), 1, 5'(i), 32'(16'hC000 + i));
    step(0, 1, 5'd21, 32'h55, 1, 5'd5, 32'hC005);
    step(0, 1, 5'd21, 32'h56, 0, '0, '0);
    idle(6);

    // Kill: queued x7<=1 superseded by ALU x7<=2
    step(0, 1, 5'd8, 32'h8, 1, 5'd7, 32'h1);
    step(0, 1, 5'd7, 32'h2, 0, '0, '0);
    idle(3);

    // Same-cycle push and ALU write to the same register: push survives
    step(0, 1, 5'd9, 32'h90, 1, 5'd9, 32'h91);
    idle(3);

    // Wrap stream with interleaved ALU writes
    for (int i = 0; i < 10; i++)
      step(0, (i % 2) == 0, 5'(i % 4 + 1), 32'(200 + i),
           1, 5'(i % 6 + 1), 32'(300 + i));
    idle(6);

`ifdef WB_HAZARD_CHECK_EN
    step(0, 0, '0, '0, 1, 5'd9, 32'h99);
    idle(4);
`endif

    // Random traffic with a 2-cycle reset in the middle
    for (int i = 0; i < 400; i++) begin
      bit rst = (i == 200 || i == 201);
      step(rst, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           $urandom, $urandom_range(0, 4) != 0,
           5'($urandom_range(0, 7)), $urandom);
    end
    idle(8);

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", 64'(expq.size()), 64'd0);
    chk("max_pend", 64'(max_cnt <= 4), 64'd1);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
